// File: rtl/rename_regfile.sv
// Architectural register file with per-register busy/tag rename status.
// Dispatch reads operands (or producer tags) on NUM_RD a/b port pairs and
// renames a destination. ROB commit writes values back. A commit only clears
// busy when its tag matches the stored tag. Flush drops every outstanding
// rename. Register 0 is hardwired to zero and is never busy.
//
// There are no valid/ready handshakes here. Each control input (alloc, commit,
// flush) is a single-cycle strobe that the block always accepts on the edge.
module rename_regfile #(
  parameter  int DATA_W   = 32,
  parameter  int NUM_REGS = 32,
  parameter  int TAG_W    = 3,
  parameter  int NUM_RD   = 2,
  localparam int AW       = $clog2(NUM_REGS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc,
  input  logic [AW-1:0]            alloc_dest,
  input  logic [TAG_W-1:0]         alloc_tag,
  input  logic                     commit,
  input  logic [AW-1:0]            commit_dest,
  input  logic [TAG_W-1:0]         commit_tag,
  input  logic [DATA_W-1:0]        commit_data,
  input  logic                     flush,
  input  logic [NUM_RD*AW-1:0]     src_a,
  input  logic [NUM_RD*AW-1:0]     src_b,
  output logic [NUM_RD*DATA_W-1:0] reg_a,
  output logic [NUM_RD*DATA_W-1:0] reg_b,
  output logic [NUM_RD-1:0]        valid_a,
  output logic [NUM_RD-1:0]        valid_b,
  output logic [NUM_RD*TAG_W-1:0]  tag_a,
  output logic [NUM_RD*TAG_W-1:0]  tag_b,
  input  logic [AW-1:0]            dbg_idx,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [AW:0]              busy_count
);

  logic [DATA_W-1:0] data_q [NUM_REGS];
  logic [TAG_W-1:0]  tag_q  [NUM_REGS];
  logic [TAG_W-1:0]  tag_d  [NUM_REGS];
  logic [NUM_REGS-1:0] valid_q, valid_d;
  logic [AW:0]         busy_q, busy_d;

  logic commit_en;
  logic alloc_en;

  assign commit_en = commit && (commit_dest != '0);
  // Flush suppresses a same-cycle rename.
  assign alloc_en  = alloc && (alloc_dest != '0) && !flush;

  // Next-state rename status: commit clears busy first, then alloc overrides.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    if (commit_en && (tag_q[commit_dest] == commit_tag)) begin
      valid_d[commit_dest] = 1'b1;
    end
    if (flush) begin
      valid_d = '1;
    end else if (alloc_en) begin
      valid_d[alloc_dest] = 1'b0;
      tag_d[alloc_dest]   = alloc_tag;
    end
    valid_d[0] = 1'b1;
  end

  // Busy count is the population count of the next-state busy flags, so the
  // +1 / -1 / 0 cases (including re-renaming a busy register) fall out directly.
  always_comb begin
    busy_d = '0;
    for (int r = 1; r < NUM_REGS; r++) begin
      if (!valid_d[r]) busy_d = busy_d + (AW+1)'(1);
    end
  end

  // State registers; data is written by every non-zero commit, even on a
  // stale tag or during flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        data_q[r] <= '0;
        tag_q[r]  <= '0;
      end
      valid_q <= '1;
      busy_q  <= '0;
    end else begin
      if (commit_en) data_q[commit_dest] <= commit_data;
      for (int r = 0; r < NUM_REGS; r++) begin
        tag_q[r] <= tag_d[r];
      end
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // One read port: {valid, tag, data}. It reflects this cycle's commit but not
  // this cycle's alloc, so dispatch sees the pre-rename producer.
  function automatic logic [DATA_W+TAG_W:0] read_port(input logic [AW-1:0] idx);
    logic [DATA_W-1:0] d;
    logic              v;
    logic [TAG_W-1:0]  t;
    if (idx == '0) begin
      d = '0;
      v = 1'b1;
      t = '0;
    end else if (commit_en && (commit_dest == idx)) begin
      d = commit_data;
      v = (tag_q[idx] == commit_tag) ? 1'b1 : valid_q[idx];
      t = tag_q[idx];
    end else begin
      d = data_q[idx];
      v = valid_q[idx];
      t = tag_q[idx];
    end
    return {v, t, d};
  endfunction

  // Combinational operand read on every a/b pair.
  always_comb begin
    logic [DATA_W+TAG_W:0] ra, rb;
    reg_a   = '0;
    reg_b   = '0;
    valid_a = '0;
    valid_b = '0;
    tag_a   = '0;
    tag_b   = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra = read_port(src_a[i*AW +: AW]);
      rb = read_port(src_b[i*AW +: AW]);
      reg_a[i*DATA_W +: DATA_W] = ra[DATA_W-1:0];
      tag_a[i*TAG_W +: TAG_W]   = ra[DATA_W +: TAG_W];
      valid_a[i]                = ra[DATA_W+TAG_W];
      reg_b[i*DATA_W +: DATA_W] = rb[DATA_W-1:0];
      tag_b[i*TAG_W +: TAG_W]   = rb[DATA_W +: TAG_W];
      valid_b[i]                = rb[DATA_W+TAG_W];
    end
  end

  assign dbg_data   = data_q[dbg_idx];
  assign busy_count = busy_q;

endmodule

// File: tb/tb_rename_regfile.sv
// Directed testbench for rename_regfile with hand-computed expectations.
module tb_rename_regfile;

  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;
  localparam int TAG_W    = 3;
  localparam int NUM_RD   = 2;
  localparam int AW       = 5;

  logic                     clk;
  logic                     rst;
  logic                     alloc;
  logic [AW-1:0]            alloc_dest;
  logic [TAG_W-1:0]         alloc_tag;
  logic                     commit;
  logic [AW-1:0]            commit_dest;
  logic [TAG_W-1:0]         commit_tag;
  logic [DATA_W-1:0]        commit_data;
  logic                     flush;
  logic [NUM_RD*AW-1:0]     src_a;
  logic [NUM_RD*AW-1:0]     src_b;
  logic [NUM_RD*DATA_W-1:0] reg_a;
  logic [NUM_RD*DATA_W-1:0] reg_b;
  logic [NUM_RD-1:0]        valid_a;
  logic [NUM_RD-1:0]        valid_b;
  logic [NUM_RD*TAG_W-1:0]  tag_a;
  logic [NUM_RD*TAG_W-1:0]  tag_b;
  logic [AW-1:0]            dbg_idx;
  logic [DATA_W-1:0]        dbg_data;
  logic [AW:0]              busy_count;

  int n_checks = 0;
  int n_errors = 0;

  rename_regfile #(
    .DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .TAG_W(TAG_W), .NUM_RD(NUM_RD)
  ) dut (
    .clk(clk), .rst(rst),
    .alloc(alloc), .alloc_dest(alloc_dest), .alloc_tag(alloc_tag),
    .commit(commit), .commit_dest(commit_dest), .commit_tag(commit_tag),
    .commit_data(commit_data), .flush(flush),
    .src_a(src_a), .src_b(src_b),
    .reg_a(reg_a), .reg_b(reg_b),
    .valid_a(valid_a), .valid_b(valid_b),
    .tag_a(tag_a), .tag_b(tag_b),
    .dbg_idx(dbg_idx), .dbg_data(dbg_data),
    .busy_count(busy_count)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Checking task
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one read port: ab=0 selects pair a, ab=1 pair b.
  task automatic check_port(input string tag, input bit ab, input int p,
                            input logic [31:0] ed, input logic ev, input logic [2:0] et);
    if (!ab) begin
      check({tag, ".data"},  64'(reg_a[p*DATA_W +: DATA_W]), 64'(ed));
      check({tag, ".valid"}, 64'(valid_a[p]),                64'(ev));
      check({tag, ".tag"},   64'(tag_a[p*TAG_W +: TAG_W]),   64'(et));
    end else begin
      check({tag, ".data"},  64'(reg_b[p*DATA_W +: DATA_W]), 64'(ed));
      check({tag, ".valid"}, 64'(valid_b[p]),                64'(ev));
      check({tag, ".tag"},   64'(tag_b[p*TAG_W +: TAG_W]),   64'(et));
    end
  endtask

  // Drivers
  task automatic idle();
    alloc = 0; alloc_dest = '0; alloc_tag = '0;
    commit = 0; commit_dest = '0; commit_tag = '0; commit_data = '0;
    flush = 0;
  endtask

  task automatic set_src(input logic [4:0] a0, input logic [4:0] a1,
                         input logic [4:0] b0, input logic [4:0] b1);
    src_a = {a1, a0};
    src_b = {b1, b0};
    #1;
  endtask

  // Advance one edge; inputs settle 1ns after it, sampling is 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic do_alloc(input logic [4:0] d, input logic [2:0] t);
    alloc = 1; alloc_dest = d; alloc_tag = t;
    tick();
  endtask

  task automatic set_commit(input logic [4:0] d, input logic [2:0] t, input logic [31:0] v);
    commit = 1; commit_dest = d; commit_tag = t; commit_data = v;
    #1;
  endtask

  initial begin
    rst = 1;
    idle();
    dbg_idx = '0;
    set_src(5'd5, 5'd7, 5'd9, 5'd31);

    // Reset state
    #3;
    check_port("rst_a0", 0, 0, 32'h0, 1'b1, 3'd0);
    check_port("rst_b1", 1, 1, 32'h0, 1'b1, 3'd0);
    check("rst_busy", 64'(busy_count), 64'd0);
    check("rst_dbg",  64'(dbg_data),   64'd0);
    @(negedge clk);
    rst = 0;
    tick();

    // r5 gets a value, then goes busy with tag 3, then async reset mid-cycle
    set_commit(5'd5, 3'd0, 32'h55);
    tick();
    do_alloc(5'd5, 3'd3);
    check_port("r5_busy", 0, 0, 32'h55, 1'b0, 3'd3);
    check("r5_busy_cnt", 64'(busy_count), 64'd1);
    #2;
    rst = 1;
    #1;
    check_port("async_rst", 0, 0, 32'h0, 1'b1, 3'd0);
    check("async_rst_cnt", 64'(busy_count), 64'd0);
    @(negedge clk);
    rst = 0;
    tick();

    // Alloc r7 tag 2, then matching commit with bypass
    do_alloc(5'd7, 3'd2);
    check_port("r7_alloc", 0, 1, 32'h0, 1'b0, 3'd2);
    check("r7_alloc_cnt", 64'(busy_count), 64'd1);
    dbg_idx = 5'd7;
    set_commit(5'd7, 3'd2, 32'hDEADBEEF);
    check_port("r7_bypass", 0, 1, 32'hDEADBEEF, 1'b1, 3'd2);
    check("r7_dbg_nobypass", 64'(dbg_data), 64'd0);
    tick();
    check_port("r7_done", 0, 1, 32'hDEADBEEF, 1'b1, 3'd2);
    check("r7_done_cnt", 64'(busy_count), 64'd0);
    check("r7_dbg", 64'(dbg_data), 64'hDEADBEEF);

    // Re-rename r4, then stale commit of the older tag
    set_src(5'd0, 5'd0, 5'd0, 5'd4);
    do_alloc(5'd4, 3'd1);
    do_alloc(5'd4, 3'd5);
    check("r4_realloc_cnt", 64'(busy_count), 64'd1);
    set_commit(5'd4, 3'd1, 32'h11);
    check_port("r4_stale_bypass", 1, 1, 32'h11, 1'b0, 3'd5);
    tick();
    check_port("r4_stale", 1, 1, 32'h11, 1'b0, 3'd5);
    check("r4_stale_cnt", 64'(busy_count), 64'd1);

    // Same-cycle commit and alloc of r9
    set_src(5'd9, 5'd0, 5'd0, 5'd4);
    alloc = 1; alloc_dest = 5'd9; alloc_tag = 3'd6;
    set_commit(5'd9, 3'd0, 32'h22);
    check_port("r9_same_cycle", 0, 0, 32'h22, 1'b1, 3'd0);
    tick();
    check_port("r9_after", 0, 0, 32'h22, 1'b0, 3'd6);
    check("r9_cnt", 64'(busy_count), 64'd2);

    // Top index r31 goes busy
    do_alloc(5'd31, 3'd1);
    check("r31_cnt", 64'(busy_count), 64'd3);

    // r1..r3 busy, then flush with alloc r8 and a commit to r3
    do_alloc(5'd1, 3'd1);
    do_alloc(5'd2, 3'd2);
    do_alloc(5'd3, 3'd3);
    check("pre_flush_cnt", 64'(busy_count), 64'd6);
    flush = 1;
    alloc = 1; alloc_dest = 5'd8; alloc_tag = 3'd7;
    set_commit(5'd3, 3'd0, 32'h33);
    check("flush_not_comb", 64'(valid_a[0]), 64'd0);
    tick();
    check("flush_cnt", 64'(busy_count), 64'd0);
    set_src(5'd1, 5'd2, 5'd3, 5'd8);
    check_port("flush_r1", 0, 0, 32'h0,  1'b1, 3'd1);
    check_port("flush_r3", 1, 0, 32'h33, 1'b1, 3'd3);
    check_port("flush_r8", 1, 1, 32'h0,  1'b1, 3'd0);
    check("flush_r2_valid", 64'(valid_a[1]), 64'd1);
    set_src(5'd4, 5'd9, 5'd31, 5'd0);
    check("flush_valids", 64'({valid_a, valid_b}), 64'hF);

    // Register 0 ignores commit and alloc
    set_src(5'd0, 5'd0, 5'd0, 5'd0);
    dbg_idx = 5'd0;
    alloc = 1; alloc_dest = 5'd0; alloc_tag = 3'd4;
    set_commit(5'd0, 3'd4, 32'hFF);
    check_port("r0_a0_bypass", 0, 0, 32'h0, 1'b1, 3'd0);
    tick();
    check_port("r0_a0", 0, 0, 32'h0, 1'b1, 3'd0);
    check_port("r0_a1", 0, 1, 32'h0, 1'b1, 3'd0);
    check_port("r0_b0", 1, 0, 32'h0, 1'b1, 3'd0);
    check_port("r0_b1", 1, 1, 32'h0, 1'b1, 3'd0);
    check("r0_cnt", 64'(busy_count), 64'd0);
    check("r0_dbg", 64'(dbg_data), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
